rstack: RTL and testbench
=========================

Name: rstack

Overview:
- Return stack for the Forth core. It is the other end of the IP next-address path: it supplies `rstack_top` to the next-IP mux and captures `ip_inc` on calls.
- It also captures TOS on `>R` and returns values on `R>` / `EXIT`.
- The top entry is held in a register, so `rstack_top` is glitch-free and available at the start of every cycle. Lower entries live in a small distributed-RAM array.

Parameters:
- `rs_width`, 16: entry width. It is at least `iaddr_width`; IP values are zero-extended on push.
- `depth_log2`, 4: stack capacity is `2**depth_log2` entries (16 by default).

Ports:
- `clk`  input  1  system clock, rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `push`  input  1  push `push_data` this cycle.
- `pop`  input  1  pop top entry this cycle.
- `push_data`  input  `rs_width`  value to push (`ip_inc` or TOS, selected upstream).
- `err_clear`  input  1  clears sticky error flags.
- `rstack_top`  output  `rs_width`  current top entry; 0 when empty.
- `count`  output  `depth_log2+1`  number of valid entries, 0..`2**depth_log2`.
- `empty`  output  1  `count == 0`.
- `full`  output  1  `count == 2**depth_log2`.
- `overflow`  output  1  sticky: a push was attempted while full.
- `underflow`  output  1  sticky: a pop was attempted while empty.

Behaviour:
- Reset (sync, high):
  - `top_r`=0, `count`=0, `overflow`=0, `underflow`=0.
  - Array contents are don't-care, not cleared.
  - Reset wins over all other inputs in the same cycle, including mid-sequence push/pop.
- Storage:
  - `top_r` drives `rstack_top` directly.
  - `mem[0..2**depth_log2-2]` holds entries below top; `mem[count-2]` is next-of-top.
  - Array read is combinational (async read), write is synchronous.
- All state changes take effect on the rising edge. Latency is 1 cycle: the value pushed in cycle N is on `rstack_top` in cycle N+1.
- Operations per cycle (push, pop):
  - 0,0: hold.
  - 1,0 with `count`=0: `top_r`<=`push_data`, `count`<=1.
  - 1,0 with 0<`count`<max: `mem[count-1]`<=`top_r`, `top_r`<=`push_data`, `count`+1.
  - 1,0 with `count`=max: no state change except `overflow`<=1. Data is dropped and `top_r` is unchanged.
  - 0,1 with `count`>=2: `top_r`<=`mem[count-2]`, `count`-1.
  - 0,1 with `count`=1: `top_r`<=0, `count`<=0.
  - 0,1 with `count`=0: no state change except `underflow`<=1.
  - 1,1 with `count`>=1: replace. `top_r`<=`push_data`, `count` unchanged, array untouched. Legal when full.
  - 1,1 with `count`=0: `underflow`<=1, then acts as a push (`top_r`<=`push_data`, `count`<=1).
- Error flags:
  - `overflow` and `underflow` are set only as above and stay set until `err_clear` or `reset`.
  - If `err_clear` and a new error occur in the same cycle, the flag ends set (set wins).
- Flags:
  - `empty` and `full` are combinational decodes of registered `count`; no extra latency.
  - `count` never wraps; it saturates by rule, never by arithmetic.
- Width rules:
  - `count` is `depth_log2+1` bits, so the max value is representable.
  - Array index uses the low `depth_log2` bits of `count-1` / `count-2`, evaluated only in the legal ranges above.
- No X propagation: `rstack_top` is 0 whenever `count`=0, including after reset and after the final pop.

Test Plan:
- Reset, then push 0x0011, 0x0022, 0x0033 on consecutive cycles -> `rstack_top` reads 0x0011, 0x0022, 0x0033 in cycles 1-3 after each push; `count`=3. Three pops -> `rstack_top` 0x0022, 0x0011, 0x0000; `empty`=1; no error flags.
- Fill with 16 pushes of 0x0100+i -> `full`=1, `rstack_top`=0x010F. Push 0xBEEF -> `overflow`=1, `rstack_top` stays 0x010F, `count`=16. Pop 16 times -> tops read 0x010E down to 0x0100 then 0; `overflow` still 1.
- Pop on empty stack -> `underflow`=1, `count`=0, `rstack_top`=0. `err_clear` pulse -> `underflow`=0 next cycle. `err_clear` together with another empty pop -> `underflow` remains 1.
- Push 0x0005, then push+pop with 0x0077 -> `rstack_top`=0x0077, `count`=1. Pop -> `empty`, top 0. With `count`=16, push+pop with 0x1234 -> top 0x1234, no `overflow`.
- Push+pop on empty with 0x0042 -> `underflow`=1, `count`=1, `rstack_top`=0x0042.
- Push 0x0AAA, 0x0BBB, then assert `reset` in the same cycle as a push of 0x0CCC -> next cycle `count`=0, `rstack_top`=0, flags 0. Subsequent push 0x0DDD -> top 0x0DDD, `count`=1.

Source files
------------

// File: rtl/rstack.sv
// Return stack: registered top entry plus an async-read array for the entries below it.
// Sticky overflow/underflow flags; push+pop in the same cycle replaces the top.
module rstack #(
  parameter int rs_width   = 16,
  parameter int depth_log2 = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [rs_width-1:0]   push_data,
  input  logic                  err_clear,
  output logic [rs_width-1:0]   rstack_top,
  output logic [depth_log2:0]   count,
  output logic                  empty,
  output logic                  full,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int unsigned DEPTH = 2 ** depth_log2;
  localparam int unsigned CW    = depth_log2 + 1;
  localparam logic [CW-1:0] MAX = CW'(DEPTH);

  logic [rs_width-1:0]   mem [0:DEPTH-2];

  logic [rs_width-1:0]   top_q, top_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;

  logic [CW-1:0]         cnt_m1, cnt_m2;
  logic [depth_log2-1:0] mem_waddr, mem_raddr;
  logic                  mem_we;
  logic                  is_empty, is_full;

  assign is_empty  = (count_q == '0);
  assign is_full   = (count_q == MAX);
  assign cnt_m1    = count_q - CW'(1);
  assign cnt_m2    = count_q - CW'(2);
  assign mem_waddr = cnt_m1[depth_log2-1:0];
  assign mem_raddr = cnt_m2[depth_log2-1:0];

  always_comb begin
    top_d       = top_q;
    count_d     = count_q;
    overflow_d  = overflow_q & ~err_clear;
    underflow_d = underflow_q & ~err_clear;
    mem_we      = 1'b0;

    if (push && pop) begin
      // Replace: array untouched; on an empty stack it degrades to a flagged push.
      top_d = push_data;
      if (is_empty) begin
        underflow_d = 1'b1;
        count_d     = CW'(1);
      end
    end else if (push) begin
      if (is_full) begin
        overflow_d = 1'b1;
      end else if (is_empty) begin
        top_d   = push_data;
        count_d = CW'(1);
      end else begin
        mem_we  = 1'b1;
        top_d   = push_data;
        count_d = count_q + CW'(1);
      end
    end else if (pop) begin
      if (is_empty) begin
        underflow_d = 1'b1;
      end else if (count_q == CW'(1)) begin
        top_d   = '0;
        count_d = '0;
      end else begin
        top_d   = mem[mem_raddr];
        count_d = cnt_m1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      top_q       <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      top_q       <= top_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Array has no reset; a write during reset is harmless since count returns to 0.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= top_q;
    end
  end

  assign rstack_top = top_q;
  assign count      = count_q;
  assign empty      = is_empty;
  assign full       = is_full;
  assign overflow   = overflow_q;
  assign underflow  = underflow_q;

endmodule

// File: tb/tb_rstack.sv
// Directed testbench for rstack: hand-computed expectations for push/pop/replace,
// overflow/underflow flag behaviour and reset priority.
module tb_rstack;

  logic        clk;
  logic        reset;
  logic        push;
  logic        pop;
  logic [15:0] push_data;
  logic        err_clear;
  logic [15:0] rstack_top;
  logic [4:0]  count;
  logic        empty;
  logic        full;
  logic        overflow;
  logic        underflow;

  int checks;
  int errors;

  rstack #(
    .rs_width   (16),
    .depth_log2 (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .pop        (pop),
    .push_data  (push_data),
    .err_clear  (err_clear),
    .rstack_top (rstack_top),
    .count      (count),
    .empty      (empty),
    .full       (full),
    .overflow   (overflow),
    .underflow  (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock with the given inputs; returns #1 after the edge with inputs idle.
  task automatic cycle(input logic ps, input logic pp, input logic [15:0] d,
                       input logic clr, input logic rst);
    push      = ps;
    pop       = pp;
    push_data = d;
    err_clear = clr;
    reset     = rst;
    @(posedge clk);
    #1;
    push      = 1'b0;
    pop       = 1'b0;
    push_data = '0;
    err_clear = 1'b0;
    reset     = 1'b0;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    push      = 1'b0;
    pop       = 1'b0;
    push_data = '0;
    err_clear = 1'b0;
    reset     = 1'b1;
    @(negedge clk);
    cycle(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);

    chk("rst_top",   32'(rstack_top), 32'h0);
    chk("rst_count", 32'(count),      32'd0);
    chk("rst_empty", 32'(empty),      32'd1);
    chk("rst_full",  32'(full),       32'd0);
    chk("rst_ovf",   32'(overflow),   32'd0);
    chk("rst_unf",   32'(underflow),  32'd0);

    // Basic push/pop
    cycle(1'b1, 1'b0, 16'h0011, 1'b0, 1'b0);
    chk("push1_top", 32'(rstack_top), 32'h0011);
    cycle(1'b1, 1'b0, 16'h0022, 1'b0, 1'b0);
    chk("push2_top", 32'(rstack_top), 32'h0022);
    cycle(1'b1, 1'b0, 16'h0033, 1'b0, 1'b0);
    chk("push3_top", 32'(rstack_top), 32'h0033);
    chk("push3_cnt", 32'(count),      32'd3);
    cycle(1'b0, 1'b1, 16'h0, 1'b0, 1'b0);
    chk("pop1_top", 32'(rstack_top), 32'h0022);
    cycle(1'b0, 1'b1, 16'h0, 1'b0, 1'b0);
    chk("pop2_top", 32'(rstack_top), 32'h0011);
    cycle(1'b0, 1'b1, 16'h0, 1'b0, 1'b0);
    chk("pop3_top",   32'(rstack_top), 32'h0000);
    chk("pop3_empty", 32'(empty),      32'd1);
    chk("pop3_ovf",   32'(overflow),   32'd0);
    chk("pop3_unf",   32'(underflow),  32'd0);

    // Fill, overflow, drain
    for (int unsigned i = 0; i < 16; i++) begin
      cycle(1'b1, 1'b0, 16'(32'h0100 + i), 1'b0, 1'b0);
      chk("fill_cnt", 32'(count), 32'(i + 1));
    end
    chk("fill_full", 32'(full),       32'd1);
    chk("fill_top",  32'(rstack_top), 32'h010F);
    cycle(1'b1, 1'b0, 16'hBEEF, 1'b0, 1'b0);
    chk("ovf_flag", 32'(overflow),   32'd1);
    chk("ovf_top",  32'(rstack_top), 32'h010F);
    chk("ovf_cnt",  32'(count),      32'd16);
    for (int unsigned i = 0; i < 16; i++) begin
      cycle(1'b0, 1'b1, 16'h0, 1'b0, 1'b0);
      if (i < 15) chk("drain_top", 32'(rstack_top), 32'h010E - i);
      else        chk("drain_top", 32'(rstack_top), 32'h0);
    end
    chk("drain_empty", 32'(empty),    32'd1);
    chk("drain_ovf",   32'(overflow), 32'd1);
    cycle(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
    chk("ovf_clear", 32'(overflow), 32'd0);

    // Underflow and err_clear priority
    cycle(1'b0, 1'b1, 16'h0, 1'b0, 1'b0);
    chk("unf_flag", 32'(underflow),  32'd1);
    chk("unf_cnt",  32'(count),      32'd0);
    chk("unf_top",  32'(rstack_top), 32'h0);
    cycle(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
    chk("unf_clear", 32'(underflow), 32'd0);
    cycle(1'b0, 1'b1, 16'h0, 1'b1, 1'b0);
    chk("unf_setwins", 32'(underflow), 32'd1);
    cycle(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
    chk("unf_clear2", 32'(underflow), 32'd0);

    // Replace
    cycle(1'b1, 1'b0, 16'h0005, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 16'h0077, 1'b0, 1'b0);
    chk("repl_top", 32'(rstack_top), 32'h0077);
    chk("repl_cnt", 32'(count),      32'd1);
    cycle(1'b0, 1'b1, 16'h0, 1'b0, 1'b0);
    chk("repl_pop_empty", 32'(empty),      32'd1);
    chk("repl_pop_top",   32'(rstack_top), 32'h0);

    // Replace while full
    for (int unsigned i = 0; i < 16; i++) begin
      cycle(1'b1, 1'b0, 16'(32'h0200 + i), 1'b0, 1'b0);
    end
    cycle(1'b1, 1'b1, 16'h1234, 1'b0, 1'b0);
    chk("fullrepl_top", 32'(rstack_top), 32'h1234);
    chk("fullrepl_cnt", 32'(count),      32'd16);
    chk("fullrepl_ovf", 32'(overflow),   32'd0);
    cycle(1'b0, 1'b1, 16'h0, 1'b0, 1'b0);
    chk("fullrepl_pop", 32'(rstack_top), 32'h020E);

    // Push+pop on empty
    cycle(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
    cycle(1'b1, 1'b1, 16'h0042, 1'b0, 1'b0);
    chk("pp_empty_unf", 32'(underflow),  32'd1);
    chk("pp_empty_cnt", 32'(count),      32'd1);
    chk("pp_empty_top", 32'(rstack_top), 32'h0042);

    // Reset wins over a concurrent push
    cycle(1'b1, 1'b0, 16'h0AAA, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 16'h0BBB, 1'b0, 1'b0);
    chk("pre_rst_cnt", 32'(count), 32'd3);
    cycle(1'b1, 1'b0, 16'h0CCC, 1'b0, 1'b1);
    chk("rstwin_cnt", 32'(count),      32'd0);
    chk("rstwin_top", 32'(rstack_top), 32'h0);
    chk("rstwin_unf", 32'(underflow),  32'd0);
    chk("rstwin_ovf", 32'(overflow),   32'd0);
    cycle(1'b1, 1'b0, 16'h0DDD, 1'b0, 1'b0);
    chk("post_rst_top", 32'(rstack_top), 32'h0DDD);
    chk("post_rst_cnt", 32'(count),      32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
